apb_req_bridge21: RTL and testbench

APB_REQ_BRIDGE21 -- requirements
Module: apb_req_bridge21

---
 rtl/apb_req_bridge21_pkg.sv | 18 +
 rtl/apb_req_bridge21_if.sv | 45 ++++
 rtl/apb_req_bridge21.sv | 118 +++++++++++
 tb/tb_apb_req_bridge21.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_req_bridge21_pkg.sv
// Shared types for the APB request bridge: FSM states and slave-select helpers.
package apb_bridge_pkg21;

  localparam int unsigned SelIdxWidth = 4;
  localparam int unsigned SelWidth    = 16;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess,
    StResp
  } bridge_state_e;

  function automatic logic [SelWidth-1:0] sel_onehot(input logic [SelIdxWidth-1:0] idx);
    return SelWidth'(1) << idx;
  endfunction

endpackage

// File: rtl/apb_req_bridge21_if.sv
// Request/response and APB signal bundle for the bridge; master is the bridge side.
interface apb_req_bridge21_if #(
  parameter int unsigned PADDR_WIDTH21  = 32,
  parameter int unsigned PWDATA_WIDTH21 = 32,
  parameter int unsigned PRDATA_WIDTH21 = 32
) ();
  import apb_bridge_pkg21::*;

  logic                      req_valid21;
  logic                      req_ready21;
  logic [PADDR_WIDTH21-1:0]  req_addr21;
  logic                      req_write21;
  logic [PWDATA_WIDTH21-1:0] req_wdata21;
  logic [SelIdxWidth-1:0]    req_sel21;

  logic                      rsp_valid21;
  logic                      rsp_ready21;
  logic [PRDATA_WIDTH21-1:0] rsp_rdata21;
  logic                      rsp_err21;
  logic                      rsp_timeout21;

  logic [PADDR_WIDTH21-1:0]  paddr21;
  logic                      prwd21;
  logic [PWDATA_WIDTH21-1:0] pwdata21;
  logic                      penable21;
  logic [SelWidth-1:0]       psel21;
  logic [PRDATA_WIDTH21-1:0] prdata21;
  logic                      pready21;
  logic                      pslverr21;

  modport master (
    input  req_valid21, req_addr21, req_write21, req_wdata21, req_sel21, rsp_ready21,
           prdata21, pready21, pslverr21,
    output req_ready21, rsp_valid21, rsp_rdata21, rsp_err21, rsp_timeout21,
           paddr21, prwd21, pwdata21, penable21, psel21
  );

  modport slave (
    output req_valid21, req_addr21, req_write21, req_wdata21, req_sel21, rsp_ready21,
           prdata21, pready21, pslverr21,
    input  req_ready21, rsp_valid21, rsp_rdata21, rsp_err21, rsp_timeout21,
           paddr21, prwd21, pwdata21, penable21, psel21
  );

endinterface

// File: rtl/apb_req_bridge21.sv
// Single-outstanding request/response to APB bridge with optional ACCESS-phase timeout.
module apb_req_bridge21
  import apb_bridge_pkg21::*;
#(
  parameter int unsigned PADDR_WIDTH21    = 32,
  parameter int unsigned PWDATA_WIDTH21   = 32,
  parameter int unsigned PRDATA_WIDTH21   = 32,
  parameter int unsigned TIMEOUT_CYCLES21 = 16
) (
  input logic                pclock21,
  input logic                preset21,
  apb_req_bridge21_if.master bus
);

  // A zero timeout still needs a one-bit counter to keep the declarations legal.
  localparam int unsigned CntWidth =
      (TIMEOUT_CYCLES21 > 0) ? $clog2(TIMEOUT_CYCLES21 + 1) : 1;
  localparam bit                  TimeoutEn = (TIMEOUT_CYCLES21 != 0);
  localparam logic [CntWidth-1:0] CntLast   = CntWidth'(TIMEOUT_CYCLES21 - 1);

  bridge_state_e             state_q, state_d;
  logic [PADDR_WIDTH21-1:0]  paddr_q, paddr_d;
  logic                      prwd_q, prwd_d;
  logic [PWDATA_WIDTH21-1:0] pwdata_q, pwdata_d;
  logic [SelIdxWidth-1:0]    sel_q, sel_d;
  logic [PRDATA_WIDTH21-1:0] rdata_q, rdata_d;
  logic                      err_q, err_d;
  logic                      tout_q, tout_d;
  logic [CntWidth-1:0]       cnt_q, cnt_d;

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    prwd_d   = prwd_q;
    pwdata_d = pwdata_q;
    sel_d    = sel_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    tout_d   = tout_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (bus.req_valid21) begin
          paddr_d  = bus.req_addr21;
          prwd_d   = bus.req_write21;
          pwdata_d = bus.req_wdata21;
          sel_d    = bus.req_sel21;
          state_d  = StSetup;
        end
      end
      StSetup: begin
        cnt_d   = '0;
        state_d = StAccess;
      end
      StAccess: begin
        // A slave response in the limit cycle takes priority over the timeout.
        if (bus.pready21) begin
          rdata_d = prwd_q ? '0 : bus.prdata21;
          err_d   = bus.pslverr21;
          tout_d  = 1'b0;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (TimeoutEn && (cnt_q == CntLast)) begin
            rdata_d = '0;
            err_d   = 1'b1;
            tout_d  = 1'b1;
            state_d = StResp;
          end
        end
      end
      StResp: begin
        if (bus.rsp_ready21) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge pclock21) begin
    if (preset21) begin
      state_q  <= StIdle;
      paddr_q  <= '0;
      prwd_q   <= 1'b0;
      pwdata_q <= '0;
      sel_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      tout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      prwd_q   <= prwd_d;
      pwdata_q <= pwdata_d;
      sel_q    <= sel_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      tout_q   <= tout_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.req_ready21   = (state_q == StIdle);
  assign bus.psel21        = ((state_q == StSetup) || (state_q == StAccess)) ?
                             sel_onehot(sel_q) : '0;
  assign bus.penable21     = (state_q == StAccess);
  assign bus.paddr21       = paddr_q;
  assign bus.prwd21        = prwd_q;
  assign bus.pwdata21      = pwdata_q;
  assign bus.rsp_valid21   = (state_q == StResp);
  assign bus.rsp_rdata21   = rdata_q;
  assign bus.rsp_err21     = err_q;
  assign bus.rsp_timeout21 = tout_q;

endmodule

// File: tb/tb_apb_req_bridge21.sv
// Scoreboard bench for apb_req_bridge21 with a programmable APB slave model.
module tb_apb_req_bridge21;
  import apb_bridge_pkg21::*;

  logic pclock21 = 1'b0;
  logic preset21 = 1'b1;
  always #5 pclock21 = ~pclock21;

  apb_req_bridge21_if bus ();

  apb_req_bridge21 #(
    .TIMEOUT_CYCLES21(4)
  ) dut (
    .pclock21(pclock21),
    .preset21(preset21),
    .bus     (bus)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        tout;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Slave model: pready rises after slv_wait wait states unless the slave hangs.
  int unsigned slv_wait  = 0;
  bit          slv_hang  = 1'b0;
  logic [31:0] slv_rdata = '0;
  logic        slv_err   = 1'b0;
  int unsigned acc_cnt   = 0;

  always_ff @(posedge pclock21) begin
    acc_cnt <= (bus.penable21 && !bus.pready21) ? acc_cnt + 1 : 0;
  end

  always_comb begin
    bus.pready21  = bus.penable21 && !slv_hang && (acc_cnt >= slv_wait);
    bus.prdata21  = slv_rdata;
    bus.pslverr21 = slv_err;
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Response monitor pops the scoreboard on every response handshake.
  always @(negedge pclock21) begin
    if (!preset21 && bus.rsp_valid21 && bus.rsp_ready21) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_unexpected", 64'(sb_q.size()), 64'd1);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_eq("sb_rdata", 64'(bus.rsp_rdata21), 64'(e.rdata));
        check_eq("sb_err", 64'(bus.rsp_err21), 64'(e.err));
        check_eq("sb_timeout", 64'(bus.rsp_timeout21), 64'(e.tout));
      end
    end
  end

  task automatic tick();
    @(posedge pclock21);
    #1;
  endtask

  // Issues one request from IDLE and returns in the SETUP cycle.
  task automatic do_req(input logic [3:0] sel, input logic [31:0] addr, input logic wr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err, input logic exp_tout);
    int n = 0;
    while (!bus.req_ready21 && n < 20) begin
      tick();
      n++;
    end
    check_eq("req_ready_wait", 64'(bus.req_ready21), 64'd1);
    bus.req_valid21 = 1'b1;
    bus.req_sel21   = sel;
    bus.req_addr21  = addr;
    bus.req_write21 = wr;
    bus.req_wdata21 = wdata;
    sb_q.push_back('{rdata: exp_rdata, err: exp_err, tout: exp_tout});
    tick();
    bus.req_valid21 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] exp_psel [8] = '{16'h1, 16'h1, 16'h0, 16'h0, 16'h2, 16'h2, 16'h0, 16'h0};
    logic        exp_rspv [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        exp_rdy  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    bus.req_valid21 = 1'b0;
    bus.req_addr21  = '0;
    bus.req_write21 = 1'b0;
    bus.req_wdata21 = '0;
    bus.req_sel21   = '0;
    bus.rsp_ready21 = 1'b1;

    // Reset values
    tick();
    tick();
    preset21 = 1'b0;
    check_eq("rst_req_ready", 64'(bus.req_ready21), 64'd1);
    check_eq("rst_psel", 64'(bus.psel21), 64'd0);
    check_eq("rst_penable", 64'(bus.penable21), 64'd0);
    check_eq("rst_paddr", 64'(bus.paddr21), 64'd0);
    check_eq("rst_prwd", 64'(bus.prwd21), 64'd0);
    check_eq("rst_pwdata", 64'(bus.pwdata21), 64'd0);
    check_eq("rst_rsp_valid", 64'(bus.rsp_valid21), 64'd0);
    check_eq("rst_rsp_rdata", 64'(bus.rsp_rdata21), 64'd0);
    check_eq("rst_rsp_err", 64'(bus.rsp_err21), 64'd0);
    check_eq("rst_rsp_timeout", 64'(bus.rsp_timeout21), 64'd0);

    // Zero-wait read, sel 3
    slv_rdata = 32'hCAFE0001;
    do_req(4'd3, 32'h10, 1'b0, 32'h0, 32'hCAFE0001, 1'b0, 1'b0);
    check_eq("rd_setup_psel", 64'(bus.psel21), 64'h0008);
    check_eq("rd_setup_penable", 64'(bus.penable21), 64'd0);
    check_eq("rd_setup_paddr", 64'(bus.paddr21), 64'h10);
    check_eq("rd_setup_rspv", 64'(bus.rsp_valid21), 64'd0);
    tick();
    check_eq("rd_access_psel", 64'(bus.psel21), 64'h0008);
    check_eq("rd_access_penable", 64'(bus.penable21), 64'd1);
    check_eq("rd_access_rspv", 64'(bus.rsp_valid21), 64'd0);
    tick();
    check_eq("rd_resp_rspv", 64'(bus.rsp_valid21), 64'd1);
    check_eq("rd_resp_psel", 64'(bus.psel21), 64'd0);
    check_eq("rd_resp_rdata", 64'(bus.rsp_rdata21), 64'hCAFE0001);
    tick();
    check_eq("rd_idle_ready", 64'(bus.req_ready21), 64'd1);
    check_eq("rd_idle_rspv", 64'(bus.rsp_valid21), 64'd0);

    // Write, two wait states, slave error; read data must not leak into the response
    slv_wait  = 2;
    slv_err   = 1'b1;
    slv_rdata = 32'hDEADBEEF;
    do_req(4'd15, 32'h24, 1'b1, 32'h5A5A5A5A, 32'h0, 1'b1, 1'b0);
    check_eq("wr_setup_psel", 64'(bus.psel21), 64'h8000);
    check_eq("wr_setup_prwd", 64'(bus.prwd21), 64'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("wr_access_penable", 64'(bus.penable21), 64'd1);
      check_eq("wr_access_psel", 64'(bus.psel21), 64'h8000);
      check_eq("wr_access_pwdata", 64'(bus.pwdata21), 64'h5A5A5A5A);
    end
    tick();
    check_eq("wr_resp_rspv", 64'(bus.rsp_valid21), 64'd1);
    check_eq("wr_resp_err", 64'(bus.rsp_err21), 64'd1);
    tick();
    check_eq("wr_idle_paddr_hold", 64'(bus.paddr21), 64'h24);
    check_eq("wr_idle_pwdata_hold", 64'(bus.pwdata21), 64'h5A5A5A5A);
    slv_err = 1'b0;

    // Hung slave hits the 4-cycle timeout
    slv_hang  = 1'b1;
    slv_rdata = 32'h77777777;
    do_req(4'd2, 32'h30, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq("to_access_penable", 64'(bus.penable21), 64'd1);
    end
    tick();
    check_eq("to_resp_psel", 64'(bus.psel21), 64'd0);
    check_eq("to_resp_timeout", 64'(bus.rsp_timeout21), 64'd1);
    check_eq("to_resp_err", 64'(bus.rsp_err21), 64'd1);
    check_eq("to_resp_rdata", 64'(bus.rsp_rdata21), 64'd0);
    tick();

    // pready in the limit cycle wins over the timeout
    slv_hang  = 1'b0;
    slv_wait  = 3;
    slv_rdata = 32'h12345678;
    do_req(4'd2, 32'h34, 1'b0, 32'h0, 32'h12345678, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq("lim_access_penable", 64'(bus.penable21), 64'd1);
    end
    tick();
    check_eq("lim_resp_rspv", 64'(bus.rsp_valid21), 64'd1);
    check_eq("lim_resp_timeout", 64'(bus.rsp_timeout21), 64'd0);
    tick();

    // Response back-pressure with a second request waiting
    slv_wait        = 0;
    slv_rdata       = 32'hAAAA0001;
    bus.rsp_ready21 = 1'b0;
    do_req(4'd5, 32'h40, 1'b0, 32'h0, 32'hAAAA0001, 1'b0, 1'b0);
    tick();
    tick();
    slv_rdata       = 32'hBBBB0002;
    bus.req_valid21 = 1'b1;
    bus.req_sel21   = 4'd6;
    bus.req_addr21  = 32'h44;
    bus.req_write21 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check_eq("bp_rspv", 64'(bus.rsp_valid21), 64'd1);
      check_eq("bp_req_ready", 64'(bus.req_ready21), 64'd0);
      check_eq("bp_rdata", 64'(bus.rsp_rdata21), 64'hAAAA0001);
      tick();
    end
    bus.rsp_ready21 = 1'b1;
    tick();
    check_eq("bp_idle_ready", 64'(bus.req_ready21), 64'd1);
    sb_q.push_back('{rdata: 32'hBBBB0002, err: 1'b0, tout: 1'b0});
    tick();
    bus.req_valid21 = 1'b0;
    check_eq("bp_b_setup_psel", 64'(bus.psel21), 64'h0040);
    tick();
    tick();
    check_eq("bp_b_resp_rspv", 64'(bus.rsp_valid21), 64'd1);
    tick();

    // Reset during the second ACCESS wait cycle
    slv_hang = 1'b1;
    do_req(4'd9, 32'h50, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    check_eq("rs_access_penable", 64'(bus.penable21), 64'd1);
    preset21 = 1'b1;
    tick();
    check_eq("rs_psel", 64'(bus.psel21), 64'd0);
    check_eq("rs_penable", 64'(bus.penable21), 64'd0);
    check_eq("rs_rspv", 64'(bus.rsp_valid21), 64'd0);
    preset21 = 1'b0;
    sb_q.delete();
    slv_hang = 1'b0;
    check_eq("rs_req_ready", 64'(bus.req_ready21), 64'd1);

    // Back-to-back reads to sel 0 then sel 1
    slv_rdata       = 32'h0B0B0B0B;
    bus.req_valid21 = 1'b1;
    bus.req_sel21   = 4'd0;
    bus.req_addr21  = 32'h100;
    bus.req_write21 = 1'b0;
    sb_q.push_back('{rdata: 32'h0B0B0B0B, err: 1'b0, tout: 1'b0});
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 0) begin
        bus.req_sel21  = 4'd1;
        bus.req_addr21 = 32'h104;
      end
      if (i == 3) sb_q.push_back('{rdata: 32'h0B0B0B0B, err: 1'b0, tout: 1'b0});
      if (i == 4) bus.req_valid21 = 1'b0;
      check_eq("b2b_psel", 64'(bus.psel21), 64'(exp_psel[i]));
      check_eq("b2b_rspv", 64'(bus.rsp_valid21), 64'(exp_rspv[i]));
      check_eq("b2b_req_ready", 64'(bus.req_ready21), 64'(exp_rdy[i]));
    end
    tick();

    check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
